// File: rtl/fs_structural.sv
// Ripple-borrow subtractor: d = a - b - c (mod 2^WIDTH), br = borrow-out.
// Each bit is two half-subtractor cells joined by an OR on their borrows.
// The outputs are either registered (one cycle of latency) or purely combinational.
module fs_structural #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] d,
  output logic             br
);

  logic [WIDTH-1:0] d_d;
  logic             br_d;

  // Each bit cell keeps its borrow signals local. The next cell reads them
  // hierarchically, so the chain never runs through one shared vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bin;   // borrow into this bit
    logic x;     // first half-subtractor difference
    logic p;     // first half-subtractor borrow
    logic q;     // second half-subtractor borrow
    logic bout;  // borrow out of this bit

    if (i == 0) begin : g_first
      assign bin = c;
    end else begin : g_next
      assign bin = g_bit[i-1].bout;
    end

    // Half subtractor 1: a[i] - b[i]
    assign x = a[i] ^ b[i];
    assign p = ~a[i] & b[i];

    // Half subtractor 2: x - bin
    assign d_d[i] = x ^ bin;
    assign q      = ~x & bin;

    assign bout = p | q;
  end

  assign br_d = g_bit[WIDTH-1].bout;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] d_q;
    logic             br_q;

    // Capture the result every cycle; async reset clears it immediately
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q  <= '0;
        br_q <= 1'b0;
      end else begin
        d_q  <= d_d;
        br_q <= br_d;
      end
    end

    assign d  = d_q;
    assign br = br_q;
  end else begin : g_comb
    // Clock and reset are not used in the combinational configuration
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign d  = d_d;
    assign br = br_d;
  end

endmodule

// File: tb/tb_fs_structural.sv
// Self-checking bench for fs_structural. It covers reset, the exhaustive
// 1-bit table in registered and combinational builds, latency, 4-bit boundary
// cases, and a random stream with a short reset pulse.
module tb_fs_structural;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, c1;
  logic       d1r, br1r;
  logic       a1c, b1c, c1c;
  logic       d1c, br1c;
  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] d4;
  logic       br4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] sb_q[$];

  // Expected {br, d} for 1-bit inputs {a, b, c}
  logic [1:0] fs_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  // 4-bit boundary vectors and expected {br, d}
  logic [3:0] w4_a   [4] = '{4'd5, 4'd3, 4'd0,  4'd9};
  logic [3:0] w4_b   [4] = '{4'd3, 4'd5, 4'd15, 4'd9};
  logic       w4_c   [4] = '{1'b0, 1'b0, 1'b1,  1'b1};
  logic [4:0] w4_exp [4] = '{5'h02, 5'h1E, 5'h10, 5'h1F};

  always #5 clk = ~clk;

  fs_structural #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .d(d1r), .br(br1r)
  );

  fs_structural #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
    .clk(clk), .rst_n(rst_n), .a(a1c), .b(b1c), .c(c1c), .d(d1c), .br(br1c)
  );

  fs_structural #(.WIDTH(4), .REG_OUT(1'b1)) u_w4r (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .d(d4), .br(br4)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  // An empty scoreboard returns an impossible value, so the check fails
  task automatic sb_check(input string tag, input logic [7:0] got);
    logic [7:0] exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hEE;
    check_eq(tag, got, exp);
  endtask

  function automatic logic [4:0] fs4_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
    return {1'b0, a} - {1'b0, b} - {4'b0, c};
  endfunction

  initial begin
    rst_n = 1'b1;
    {a1, b1, c1}    = 3'b100;
    {a1c, b1c, c1c} = 3'b100;
    a4 = 4'd5; b4 = 4'd0; c4 = 1'b0;

    // Asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #1 check_eq("rst_async_w1", {6'b0, br1r, d1r}, 8'h00);
    check_eq("rst_async_w4", {3'b0, br4, d4}, 8'h00);

    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_hold_w1", {6'b0, br1r, d1r}, 8'h00);
      check_eq("rst_hold_w4", {3'b0, br4, d4}, 8'h00);
    end
    // The combinational build ignores reset
    check_eq("comb_ignores_rst", {6'b0, br1c, d1c}, 8'h01);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("first_load", {6'b0, br1r, d1r}, 8'h01);
    #2 rst_n = 1'b0;
    #1 check_eq("async_clear_mid", {6'b0, br1r, d1r}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Exhaustive 1-bit registered table
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      {a1, b1, c1} = 3'(v);
      sb_q.push_back({6'b0, fs_tab[v]});
      @(posedge clk); #1;
      sb_check("w1_reg_tab", {6'b0, br1r, d1r});
    end

    // Latency: a mid-cycle input change must not show before the next edge
    @(negedge clk) {a1, b1, c1} = 3'b100;
    @(posedge clk); #1;
    check_eq("lat_load", {6'b0, br1r, d1r}, 8'h01);
    #2 {a1, b1, c1} = 3'b011;
    #1 check_eq("lat_hold", {6'b0, br1r, d1r}, 8'h01);
    @(posedge clk); #1;
    check_eq("lat_next", {6'b0, br1r, d1r}, 8'h02);

    // Exhaustive 1-bit combinational table
    for (int v = 0; v < 8; v++) begin
      {a1c, b1c, c1c} = 3'(v);
      sb_q.push_back({6'b0, fs_tab[v]});
      #1 sb_check("w1_comb_tab", {6'b0, br1c, d1c});
      #19;
    end

    // 4-bit boundary vectors
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a4 = w4_a[k]; b4 = w4_b[k]; c4 = w4_c[k];
      sb_q.push_back({3'b0, w4_exp[k]});
      @(posedge clk); #1;
      sb_check("w4_bound", {3'b0, br4, d4});
    end

    // Random stream with a short reset pulse before one capture edge
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      c4 = 1'($urandom_range(0, 1));
      sb_q.push_back({3'b0, fs4_model(a4, b4, c4)});
      if (i == 10) begin
        #1 rst_n = 1'b0;
        #1 check_eq("pulse_zero", {3'b0, br4, d4}, 8'h00);
        #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
      sb_check("w4_rand", {3'b0, br4, d4});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fs_structural.md
Name: fs_structural

Overview:
- Full subtractor computing difference and borrow-out of minuend a, subtrahend b and borrow-in c.
- Datapath is built structurally from two half-subtractor cells plus an OR gate per bit, chained as a ripple-borrow WIDTH-bit subtractor.
- Outputs are registered on one clock so the block drops into synchronous arithmetic pipelines.
- Default configuration (WIDTH=1) is the classic 1-bit full subtractor.

Parameters:
- WIDTH, 1, operand and difference width in bits (>=1).
- REG_OUT, 1, 1 = d/br registered (1-cycle latency); 0 = d/br driven combinationally from the subtractor chain (clk/rst_n then unused).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c  input  1  borrow-in, applied at bit 0.
- d  output  WIDTH  difference, a - b - c modulo 2^WIDTH.
- br  output  1  borrow-out; 1 when a < b + c (unsigned).

Behaviour:
- Per-bit cell i, with borrow-in bin(0)=c and bin(i+1)=bout(i):
  - half subtractor 1: x = a[i] ^ b[i]; p = ~a[i] & b[i].
  - half subtractor 2: d[i] = x ^ bin(i); q = ~x & bin(i).
  - bout(i) = p | q.
  - br = bout(WIDTH-1).
- WIDTH=1 equivalents: d = a^b^c; br = (~a&b) | (~a&c) | (b&c).
- Arithmetic is unsigned. For WIDTH=1, {br,d} is the 2-bit two's-complement encoding of a-b-c: 0-0-0 -> 00; 1-1-1 -> 11 (-1); 0-1-1 -> 10 (-2).
- REG_OUT=1:
  - d and br are captured on each rising clk edge from the current a, b, c.
  - Latency is exactly 1 cycle; a new result every cycle; no handshake.
  - rst_n low asynchronously forces d=0 and br=0 immediately, regardless of clk.
  - Outputs hold 0 while rst_n is low.
  - After rst_n deasserts (sampled high at a clk edge), the first rising edge loads the result of the inputs present at that edge.
  - Reset asserted mid-stream discards the pending result; no recovery of lost values.
- REG_OUT=0:
  - d and br follow the inputs combinationally; no storage.
  - rst_n has no effect.
- No X propagation handling beyond standard gate semantics; the inputs are required to be driven.
- Boundary cases (all follow from the arithmetic rules):
  - a=0, b=all-ones, c=1 -> d=0, br=1.
  - a=b, c=0 -> d=0, br=0.
  - a=b, c=1 -> d=all-ones, br=1.

Test Plan:
- Reset: hold rst_n=0 with a=1, b=0, c=0 and toggle clk -> d=0, br=0 throughout; assert rst_n asynchronously between edges -> outputs clear without a clk edge.
- Exhaustive WIDTH=1, REG_OUT=1, one vector per cycle, checked one cycle later. Expected (a,b,c -> d,br):
  - 000 -> 0,0
  - 001 -> 1,1
  - 010 -> 1,1
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,0
  - 110 -> 0,0
  - 111 -> 1,1
- Latency: change inputs from 100 to 011 mid-cycle -> outputs stay 1,0 until the next rising edge, then become 0,1.
- REG_OUT=0, WIDTH=1: the same 8 vectors at 20-time-unit spacing -> outputs match the table within the same timestep with no clock.
- WIDTH=4, REG_OUT=1:
  - a=5, b=3, c=0 -> d=2, br=0.
  - a=3, b=5, c=0 -> d=14, br=1.
  - a=0, b=15, c=1 -> d=0, br=1.
  - a=9, b=9, c=1 -> d=15, br=1.
- Mid-stream reset: stream random vectors, pulse rst_n low for less than one cycle -> outputs 0 during the pulse; next edge after release resumes correct results.
